// File: rtl/ulpi_pkg.sv
// Shared constants, state encoding and byte helpers for the ULPI register-write link.
// Defining ULPI_EXT_REG_EN adds the extended-address state.
package ulpi_pkg;

    localparam logic [1:0] TXCMD_REGW   = 2'b10;
    localparam logic [1:0] TXCMD_REGR   = 2'b11;
    localparam logic [5:0] EXT_REG_ADDR = 6'h2F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TXCMD   = 3'd1,
`ifdef ULPI_EXT_REG_EN
        ST_EXTADDR = 3'd2,
`endif
        ST_DATA    = 3'd3,
        ST_STOP    = 3'd4,
        ST_BUSWAIT = 3'd5,
        ST_TURN    = 3'd6
    } state_e;

    // Register-write TXCMD byte; extended addresses send the escape code instead.
    function automatic logic [7:0] txcmd_byte(input logic [5:0] addr, input logic ext);
        logic [7:0] v;
        if (ext) begin
            v = {TXCMD_REGW, EXT_REG_ADDR};
        end else begin
            v = {TXCMD_REGW, addr};
        end
        return v;
    endfunction

    function automatic logic addr_is_ext(input logic [7:0] addr);
        return (addr >= {2'b00, EXT_REG_ADDR});
    endfunction

endpackage

// File: rtl/ulpi_reg_write.sv
// ULPI link-side register write: TXCMD / (EXTADDR) / DATA / STOP with PHY takeover retry and nxt timeout.
// Defining ULPI_EXT_REG_EN enables the extended register address sequence.
module ulpi_reg_write
    import ulpi_pkg::*;
#(
    parameter int MAX_RETRIES = 3,
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_req,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    inout  wire  [7:0] ulpi_data
);

    localparam int TMO_W = (NXT_TIMEOUT > 1) ? $clog2(NXT_TIMEOUT) : 1;
    localparam int RTY_W = $clog2(MAX_RETRIES + 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(NXT_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
`ifdef ULPI_EXT_REG_EN
    localparam int ADDR_W = 8;
`else
    localparam int ADDR_W = 6;
`endif

    state_e             r_state;
    state_e             w_state_nxt;
    state_e             w_hs_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_data;
    logic [RTY_W-1:0]   r_retry;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_stp;
    logic               r_drive;
    logic [7:0]         r_tx;

    logic               w_capture;
    logic               w_addr_ok;
    logic [ADDR_W-1:0]  w_addr_in;
    logic [ADDR_W-1:0]  w_addr_eff;
    logic [7:0]         w_data_eff;
    logic               w_ext_eff;
    logic [RTY_W-1:0]   w_retry_inc;
    logic [RTY_W-1:0]   w_retry_nxt;
    logic [RTY_W-1:0]   w_hs_retry;
    logic               w_hs_error;
    logic               w_done_nxt;
    logic               w_error_nxt;
    logic               w_drive_nxt;
    logic               w_stp_nxt;
    logic [7:0]         w_tx_nxt;

`ifdef ULPI_EXT_REG_EN
    assign w_addr_ok = 1'b1;
    assign w_addr_in = wr_addr;
    assign w_ext_eff = addr_is_ext(w_addr_eff);
`else
    // Only the low six address bits are ever sent; the top two merely qualify the request.
    assign w_addr_ok = (wr_addr[7:6] == 2'b00);
    assign w_addr_in = wr_addr[5:0];
    assign w_ext_eff = 1'b0;
`endif

    assign w_addr_eff  = w_capture ? w_addr_in : r_addr;
    assign w_data_eff  = w_capture ? wr_data : r_data;
    assign w_retry_inc = r_retry + RTY_W'(1);

    // One cycle of any nxt handshake state: takeover beats progress, progress beats timeout.
    always_comb begin
        w_hs_state = r_state;
        w_hs_error = 1'b0;
        w_hs_retry = r_retry;
        if (ulpi_dir) begin
            w_hs_retry = w_retry_inc;
            if (w_retry_inc > RTY_MAX) begin
                w_hs_error = 1'b1;
                w_hs_state = ST_IDLE;
            end else begin
                w_hs_state = ST_BUSWAIT;
            end
        end else if (ulpi_nxt) begin
            case (r_state)
`ifdef ULPI_EXT_REG_EN
                ST_TXCMD:   w_hs_state = w_ext_eff ? ST_EXTADDR : ST_DATA;
                ST_EXTADDR: w_hs_state = ST_DATA;
`else
                ST_TXCMD:   w_hs_state = ST_DATA;
`endif
                ST_DATA:    w_hs_state = ST_STOP;
                default:    w_hs_state = ST_IDLE;
            endcase
        end else if (r_tmo == TMO_LAST) begin
            w_hs_error = 1'b1;
            w_hs_state = ST_IDLE;
        end else begin
            w_hs_state = r_state;
        end
    end

    // Next-state, capture and status-pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retry_nxt = r_retry;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_req) begin
                    w_capture   = 1'b1;
                    w_retry_nxt = {RTY_W{1'b0}};
                    if (!w_addr_ok) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (ulpi_dir) begin
                        w_state_nxt = ST_BUSWAIT;
                    end else begin
                        w_state_nxt = ST_TXCMD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TXCMD, ST_DATA: begin
                w_state_nxt = w_hs_state;
                w_error_nxt = w_hs_error;
                w_retry_nxt = w_hs_retry;
            end
`ifdef ULPI_EXT_REG_EN
            ST_EXTADDR: begin
                w_state_nxt = w_hs_state;
                w_error_nxt = w_hs_error;
                w_retry_nxt = w_hs_retry;
            end
`endif
            // The PHY has latched the data by now, so a late takeover still counts as success.
            ST_STOP: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            ST_BUSWAIT: begin
                if (!ulpi_dir) begin
                    w_state_nxt = ST_TURN;
                end else begin
                    w_state_nxt = ST_BUSWAIT;
                end
            end
            ST_TURN: w_state_nxt = ST_TXCMD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus byte, drive enable and stp for the state being entered.
    always_comb begin
        w_drive_nxt = 1'b0;
        w_stp_nxt   = 1'b0;
        w_tx_nxt    = 8'h00;
        case (w_state_nxt)
            ST_TXCMD: begin
                w_drive_nxt = 1'b1;
                w_tx_nxt    = txcmd_byte(w_addr_eff[5:0], w_ext_eff);
            end
`ifdef ULPI_EXT_REG_EN
            ST_EXTADDR: begin
                w_drive_nxt = 1'b1;
                w_tx_nxt    = w_addr_eff;
            end
`endif
            ST_DATA: begin
                w_drive_nxt = 1'b1;
                w_tx_nxt    = w_data_eff;
            end
            ST_STOP: begin
                w_drive_nxt = 1'b1;
                w_stp_nxt   = 1'b1;
                w_tx_nxt    = 8'h00;
            end
            default: begin
                w_drive_nxt = 1'b0;
                w_stp_nxt   = 1'b0;
                w_tx_nxt    = 8'h00;
            end
        endcase
    end

    // State, captured request, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_data  <= 8'h00;
            r_retry <= {RTY_W{1'b0}};
            r_tmo   <= {TMO_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_stp   <= 1'b0;
            r_drive <= 1'b0;
            r_tx    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_addr <= w_addr_in;
                r_data <= wr_data;
            end
            r_retry <= w_retry_nxt;
            r_tmo   <= (w_state_nxt != r_state) ? {TMO_W{1'b0}} : (r_tmo + TMO_W'(1));
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
            r_stp   <= w_stp_nxt;
            r_drive <= w_drive_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign ulpi_stp = r_stp;
    // dir gates the driver directly so the bus is released in the same cycle the PHY claims it.
    assign ulpi_data = (r_drive && r_busy && !ulpi_dir) ? r_tx : 8'hzz;

endmodule
